// File: rtl/axistream_pkg.sv
// Shared constants, beat record and round-robin pick function for the AXI-Stream arbiter.
package axistream_pkg;

    localparam int AXIS_DATA_W = 8;
    localparam int RR_MAX_N    = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PKT  = 1'b1;

    typedef struct packed {
        logic                   tid;
        logic                   tdest;
        logic                   tlast;
        logic                   tkeep;
        logic                   terr;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_beat_t;

    // Returns {any, index}: first set bit of valid scanning last+1, last+2, .. modulo n.
    // Scanning from the far end lets the nearest candidate overwrite the result last.
    function automatic logic [3:0] rr_pick(input logic [RR_MAX_N-1:0] valid,
                                           input logic [2:0]          last,
                                           input int                  n);
        logic [3:0] r;
        int         idx;
        r = '0;
        for (int k = n; k >= 1; k--) begin
            idx = (int'(last) + k) % n;
            if (valid[idx[2:0]]) r = {1'b1, idx[2:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/axistream_rr_grant.sv
// Combinational round-robin picker: lowest-distance requester after the previous grant.
module axistream_rr_grant
    import axistream_pkg::*;
#(
    parameter int N     = 2,
    parameter int SRC_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [SRC_W-1:0] i_last,
    output logic [SRC_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [RR_MAX_N-1:0] w_req;
    logic [2:0]          w_last;
    logic [3:0]          w_pick;

    assign w_req     = RR_MAX_N'(i_req);
    assign w_last    = 3'(i_last);
    assign w_pick    = rr_pick(w_req, w_last, N);
    assign o_gnt_idx = SRC_W'(w_pick[2:0]);
    assign o_any     = w_pick[3];

endmodule

// File: rtl/axistream_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter, round-robin, grant held through tlast, registered output.
// state | meaning
// IDLE  | no grant held; arbitrate among valid ports (one bubble cycle per packet)
// PKT   | grant held; beats of the granted port pass to the output register
module axistream_rr_arbiter
    import axistream_pkg::*;
#(
    parameter int N     = 2,
    parameter int SRC_W = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N-1:0]             s_axis_tvalid,
    output logic [N-1:0]             s_axis_tready,
    input  logic [N-1:0]             s_axis_tid,
    input  logic [N-1:0]             s_axis_tdest,
    input  logic [N-1:0]             s_axis_tlast,
    input  logic [N-1:0]             s_axis_tkeep,
    input  logic [N-1:0]             s_axis_terr,
    input  logic [AXIS_DATA_W*N-1:0] s_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tid,
    output logic                     m_axis_tdest,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tkeep,
    output logic                     m_axis_terr,
    output logic [AXIS_DATA_W-1:0]   m_axis_tdata,
    output logic [SRC_W-1:0]         m_axis_tsrc,
    output logic                     busy
);

    logic [0:0]       r_state;
    logic [SRC_W-1:0] r_grant;
    logic [SRC_W-1:0] r_last_grant;
    logic             r_out_valid;
    logic [SRC_W-1:0] r_out_src;
    axis_beat_t       r_out;

    logic [SRC_W-1:0] w_pick_idx;
    logic             w_pick_any;
    logic             w_out_free;
    logic             w_sel_valid;
    logic             w_xfer;
    axis_beat_t       w_sel;

    axistream_rr_grant #(.N(N), .SRC_W(SRC_W)) u_grant (
        .i_req     (s_axis_tvalid),
        .i_last    (r_last_grant),
        .o_gnt_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    always_comb begin
        w_sel       = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_grant == SRC_W'(i)) begin
                w_sel.tid   = s_axis_tid[i];
                w_sel.tdest = s_axis_tdest[i];
                w_sel.tlast = s_axis_tlast[i];
                w_sel.tkeep = s_axis_tkeep[i];
                w_sel.terr  = s_axis_terr[i];
                w_sel.tdata = s_axis_tdata[AXIS_DATA_W*i +: AXIS_DATA_W];
                w_sel_valid = s_axis_tvalid[i];
            end
        end
    end

    // Ready is a function of grant and output-register space only, never of tvalid.
    assign w_out_free = !r_out_valid || m_axis_tready;

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < N; i++) begin
            if (r_state == ST_PKT && r_grant == SRC_W'(i)) s_axis_tready[i] = w_out_free;
        end
    end

    assign w_xfer = (r_state == ST_PKT) && w_sel_valid && w_out_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_last_grant <= SRC_W'(N - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_any) begin
                        r_grant      <= w_pick_idx;
                        r_last_grant <= w_pick_idx;
                        r_state      <= ST_PKT;
                    end
                end
                default: begin
                    if (w_xfer && w_sel.tlast) r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_src   <= '0;
            r_out       <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_src   <= r_grant;
            r_out       <= w_sel;
        end else if (m_axis_tready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tid    = r_out.tid;
    assign m_axis_tdest  = r_out.tdest;
    assign m_axis_tlast  = r_out.tlast;
    assign m_axis_tkeep  = r_out.tkeep;
    assign m_axis_terr   = r_out.terr;
    assign m_axis_tdata  = r_out.tdata;
    assign m_axis_tsrc   = r_out_src;
    assign busy          = (r_state == ST_PKT);

endmodule

// File: tb/tb_axistream_rr_arbiter.sv
// Bench for axistream_rr_arbiter (N=4): directed packets, expected beats queued, monitor compares.
module tb_axistream_rr_arbiter;

    localparam int N     = 4;
    localparam int SRC_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     s_tvalid = '0;
    logic [N-1:0]     s_tready;
    logic [N-1:0]     s_tid = '0;
    logic [N-1:0]     s_tdest = '0;
    logic [N-1:0]     s_tlast = '0;
    logic [N-1:0]     s_tkeep = '0;
    logic [N-1:0]     s_terr = '0;
    logic [8*N-1:0]   s_tdata = '0;
    logic             m_tvalid;
    logic             m_ready = 1'b1;
    logic             m_tid, m_tdest, m_tlast, m_tkeep, m_terr;
    logic [7:0]       m_tdata;
    logic [SRC_W-1:0] m_tsrc;
    logic             busy;

    always #5 clk = ~clk;

    axistream_rr_arbiter #(.N(N), .SRC_W(SRC_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tid    (s_tid),
        .s_axis_tdest  (s_tdest),
        .s_axis_tlast  (s_tlast),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_terr   (s_terr),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_ready),
        .m_axis_tid    (m_tid),
        .m_axis_tdest  (m_tdest),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_terr   (m_terr),
        .m_axis_tdata  (m_tdata),
        .m_axis_tsrc   (m_tsrc),
        .busy          (busy)
    );

    typedef struct packed {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
        logic       id;
        logic       dest;
        logic       keep;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   sb_en = 1'b0;
    bit   rand_ready = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int p, input logic [7:0] d, input bit last);
        exp_t e;
        e.src  = p[1:0];
        e.data = d;
        e.last = last;
        e.id   = d[0];
        e.dest = d[1];
        e.keep = d[3];
        e.err  = d[2];
        return e;
    endfunction

    task automatic push_pkt(input int p, input int len, input logic [7:0] base, input logic [7:0] step);
        for (int b = 0; b < len; b++) exp_q.push_back(mk(p, base + step * 8'(b), b == len - 1));
    endtask

    // Called and returns at posedge+1; optional idle gap of gap_len cycles before beat gap_at.
    task automatic send_pkt(input int p, input int len, input logic [7:0] base, input logic [7:0] step,
                            input int gap_at, input int gap_len);
        logic [7:0] d;
        bit         hs;
        for (int b = 0; b < len; b++) begin
            if (b == gap_at) begin
                s_tvalid[p] = 1'b0;
                repeat (gap_len) @(posedge clk);
                #1;
            end
            d = base + step * 8'(b);
            s_tvalid[p]         = 1'b1;
            s_tdata[8*p +: 8]   = d;
            s_tlast[p]          = (b == len - 1);
            s_tid[p]            = d[0];
            s_tdest[p]          = d[1];
            s_tkeep[p]          = d[3];
            s_terr[p]           = d[2];
            hs = 1'b0;
            for (int c = 0; c < 300 && !hs; c++) begin
                @(negedge clk);
                hs = s_tready[p];
                @(posedge clk);
                #1;
            end
            chk("handshake", 32'(hs), 32'd1);
        end
        s_tvalid[p] = 1'b0;
        s_tlast[p]  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0 && !m_tvalid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: AXIS hold rule while stalled, and in-order scoreboard on each output handshake.
    initial begin
        exp_t got, prev, e;
        bit   prev_stall;
        prev_stall = 1'b0;
        prev       = '0;
        forever begin
            @(negedge clk);
            got = {m_tsrc, m_tdata, m_tlast, m_tid, m_tdest, m_tkeep, m_terr};
            if (rst || !sb_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold_stable", 32'(got), 32'(prev));
                if (m_tvalid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", got);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 32'(got), 32'(e));
                    end
                end
                prev_stall = m_tvalid && !m_ready;
                prev       = got;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [5:0] t1_v;
        bit [5:0] t1_b;
        t1_v = 6'b011100;
        t1_b = 6'b001110;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd0);
        chk("rst_busy",   32'(busy),     32'd0);
        chk("rst_tdata",  32'(m_tdata),  32'd0);
        chk("rst_tsrc",   32'(m_tsrc),   32'd0);
        chk("rst_tlast",  32'(m_tlast),  32'd0);
        rst   = 1'b0;
        sb_en = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet from port 0: output valid on cycles 2..4 after input valid.
        push_pkt(0, 3, 8'h11, 8'h11);
        fork
            send_pkt(0, 3, 8'h11, 8'h11, -1, 0);
            begin
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    chk("t1_tvalid", 32'(m_tvalid), 32'(t1_v[k]));
                    chk("t1_busy",   32'(busy),     32'(t1_b[k]));
                end
            end
        join
        wait_drain();

        // Ports 0 and 1 back-to-back 2-beat packets: grants alternate, no interleave.
        do_reset();
        push_pkt(0, 2, 8'h20, 8'h01);
        push_pkt(1, 2, 8'h30, 8'h01);
        push_pkt(0, 2, 8'h24, 8'h01);
        push_pkt(1, 2, 8'h34, 8'h01);
        fork
            begin
                send_pkt(0, 2, 8'h20, 8'h01, -1, 0);
                send_pkt(0, 2, 8'h24, 8'h01, -1, 0);
            end
            begin
                send_pkt(1, 2, 8'h30, 8'h01, -1, 0);
                send_pkt(1, 2, 8'h34, 8'h01, -1, 0);
            end
        join
        wait_drain();

        // Random downstream backpressure over a 5-beat packet.
        do_reset();
        rand_ready = 1'b1;
        push_pkt(1, 5, 8'h41, 8'h03);
        send_pkt(1, 5, 8'h41, 8'h03, -1, 0);
        wait_drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #1;

        // Wrap order: grant 2 first, then ports 1 and 3 request -> 3 then 1.
        do_reset();
        push_pkt(2, 2, 8'h60, 8'h01);
        push_pkt(3, 1, 8'h7D, 8'h01);
        push_pkt(1, 1, 8'h8E, 8'h01);
        fork
            send_pkt(2, 2, 8'h60, 8'h01, -1, 0);
            begin @(posedge clk); #1; send_pkt(3, 1, 8'h7D, 8'h01, -1, 0); end
            begin @(posedge clk); #1; send_pkt(1, 1, 8'h8E, 8'h01, -1, 0); end
        join
        wait_drain();

        // Granted port 2 stalls 10 cycles mid-packet; grant must be held.
        do_reset();
        push_pkt(2, 3, 8'h90, 8'h05);
        push_pkt(3, 1, 8'hA7, 8'h01);
        push_pkt(1, 1, 8'hBA, 8'h01);
        fork
            send_pkt(2, 3, 8'h90, 8'h05, 1, 10);
            begin @(posedge clk); #1; send_pkt(3, 1, 8'hA7, 8'h01, -1, 0); end
            begin @(posedge clk); #1; send_pkt(1, 1, 8'hBA, 8'h01, -1, 0); end
            begin
                @(negedge clk);
                for (int k = 1; k <= 13; k++) begin
                    @(negedge clk);
                    chk("t6_busy",        32'(busy),                32'd1);
                    chk("t6_other_ready", 32'(s_tready & 4'b1011), 32'd0);
                end
            end
        join
        wait_drain();

        // Reset asserted while beat 2 of a 4-beat packet is presented.
        do_reset();
        sb_en = 1'b0;
        s_tvalid[0] = 1'b1;
        s_tdata[7:0] = 8'h50;
        @(posedge clk); #1;
        @(posedge clk); #1;
        s_tdata[7:0] = 8'h51;
        @(posedge clk); #1;
        s_tdata[7:0] = 8'h52;
        chk("t5_pre_tvalid", 32'(m_tvalid),    32'd1);
        chk("t5_pre_tready", 32'(s_tready[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("t5_rst_tready", 32'(s_tready), 32'd0);
        chk("t5_rst_busy",   32'(busy),     32'd0);
        s_tvalid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        sb_en = 1'b1;
        push_pkt(0, 1, 8'hC3, 8'h01);
        push_pkt(1, 1, 8'hD6, 8'h01);
        fork
            send_pkt(0, 1, 8'hC3, 8'h01, -1, 0);
            send_pkt(1, 1, 8'hD6, 8'h01, -1, 0);
        join
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
